// File: rtl/bm3d_pkg.sv
// Shared constants, coordinate type and scheduler state encoding for the
// BM3D block scheduler.
package bm3d_pkg;

    localparam int unsigned DEF_IMG_W      = 640;
    localparam int unsigned DEF_IMG_H      = 480;
    localparam int unsigned DEF_BLK        = 8;
    localparam int unsigned DEF_STEP       = 3;
    localparam int unsigned DEF_CW         = 11;
    localparam int unsigned DEF_PEND_DEPTH = 4;

    typedef logic [DEF_CW-1:0] coord_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } sched_state_e;

endpackage

// File: rtl/bm3d_sync_fifo.sv
// Synchronous FIFO with flush, full/empty and simultaneous push/pop.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
// peek exposes the entry behind the head so a consumer can chain entries.
module bm3d_sync_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [W-1:0] peek,
    output logic [$clog2(DEPTH):0] count,
    output logic         full,
    output logic         empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];
    assign peek    = mem[rd_ptr + AW'(1)];

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bm3d_blk_sched.sv
// BM3D block scheduler: counts camera rows, queues stripe top rows and
// issues one (x0, y0) job per reference block over valid/ready.
// Optional macro BM3D_SCHED_STAT_EN adds the stat_jobs accepted-job counter.
module bm3d_blk_sched
    import bm3d_pkg::*;
#(
    parameter int unsigned IMG_W      = DEF_IMG_W,
    parameter int unsigned IMG_H      = DEF_IMG_H,
    parameter int unsigned BLK        = DEF_BLK,
    parameter int unsigned STEP       = DEF_STEP,
    parameter int unsigned CW         = DEF_CW,
    parameter int unsigned PEND_DEPTH = DEF_PEND_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic          cmos_de,
    output logic          job_valid,
    input  logic          job_ready,
    output logic [CW-1:0] job_x,
    output logic [CW-1:0] job_y,
    output logic          job_last,
    output logic          busy,
    output logic          frame_done,
    output logic          ovf_err,
    output logic          abort_err
`ifdef BM3D_SCHED_STAT_EN
   ,output logic [19:0]   stat_jobs
`endif
);
    localparam logic [CW-1:0] LAST_X  = CW'(IMG_W - BLK);
    localparam logic [CW-1:0] LAST_Y  = CW'(IMG_H - BLK);
    localparam logic [CW-1:0] LAST_R  = CW'(IMG_H - 1);
    localparam logic [CW-1:0] FIRST_R = CW'(BLK - 1);
    localparam int unsigned   MW      = (STEP > 1) ? $clog2(STEP) : 1;

    logic          vsync_q, href_q, de_seen;
    logic [CW-1:0] row;
    logic [MW-1:0] mphase;
    logic          push_pend;
    logic [CW-1:0] push_y;
    logic          vs_rise, hr_fall, row_done;

    sched_state_e  state, state_n;
    logic [CW-1:0] x_cur, x_n, y_cur, y_n, next_x;
    logic [CW:0]   x_step;
    logic          hs, last_col, pop, push_fire, next_avail;
    logic [CW-1:0] fifo_dout, fifo_peek;
    logic [$clog2(PEND_DEPTH):0] fifo_count;
    logic          fifo_full, fifo_empty;

    assign vs_rise  = vsync && !vsync_q;
    assign hr_fall  = href_q && !href;
    assign row_done = hr_fall && de_seen && (row <= LAST_R) && !vs_rise;

    // Camera timing front end: edge detect, row counting, stripe eligibility
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q   <= 1'b0;
            href_q    <= 1'b0;
            de_seen   <= 1'b0;
            row       <= '0;
            mphase    <= '0;
            push_pend <= 1'b0;
            push_y    <= '0;
        end else begin
            vsync_q   <= vsync;
            href_q    <= href;
            push_pend <= 1'b0;
            if (vs_rise) begin
                row     <= '0;
                mphase  <= '0;
                de_seen <= 1'b0;
            end else begin
                if (hr_fall)               de_seen <= 1'b0;
                else if (href && cmos_de)  de_seen <= 1'b1;
                if (row_done) begin
                    row <= row + CW'(1);
                    if (row >= FIRST_R) begin
                        mphase    <= (mphase == MW'(STEP - 1)) ? '0 : mphase + MW'(1);
                        push_pend <= (mphase == '0) || (row == LAST_R);
                        push_y    <= row - FIRST_R;
                    end
                end
            end
        end
    end

    assign job_valid = (state == S_ISSUE);
    assign job_x     = x_cur;
    assign job_y     = y_cur;
    assign last_col  = (x_cur == LAST_X);
    assign job_last  = job_valid && last_col && (y_cur == LAST_Y);
    assign hs        = job_valid && job_ready;
    assign pop       = hs && last_col;
    assign push_fire = push_pend && !vs_rise && (!fifo_full || pop);
    assign busy      = (state != S_IDLE) || !fifo_empty;

    // A stripe pushed while the only entry is popped is not yet visible
    // through peek, so it is forwarded directly to avoid a bubble.
    assign next_avail = (fifo_count >= 2) || push_fire;
    assign x_step     = {1'b0, x_cur} + (CW+1)'(STEP);
    assign next_x     = (x_step > {1'b0, LAST_X}) ? LAST_X : x_step[CW-1:0];

    bm3d_sync_fifo #(
        .W     (CW),
        .DEPTH (PEND_DEPTH)
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .flush (vs_rise),
        .push  (push_pend && !vs_rise),
        .din   (push_y),
        .pop   (pop),
        .dout  (fifo_dout),
        .peek  (fifo_peek),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue FSM state and coordinate registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            x_cur <= '0;
            y_cur <= '0;
        end else begin
            state <= state_n;
            x_cur <= x_n;
            y_cur <= y_n;
        end
    end

    // Issue FSM next state: walk columns, chain stripes, abort on vsync
    always_comb begin
        state_n = state;
        x_n     = x_cur;
        y_n     = y_cur;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_n = S_ISSUE;
                    x_n     = '0;
                    y_n     = fifo_dout;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    if (!last_col) begin
                        x_n = next_x;
                    end else if (next_avail) begin
                        x_n = '0;
                        y_n = (fifo_count >= 2) ? fifo_peek : push_y;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (vs_rise) state_n = S_IDLE;
    end

    // Completion pulse and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            ovf_err    <= 1'b0;
            abort_err  <= 1'b0;
        end else begin
            frame_done <= hs && job_last;
            if (push_pend && !vs_rise && fifo_full && !pop) ovf_err <= 1'b1;
            if (vs_rise && (!fifo_empty || state == S_ISSUE)) abort_err <= 1'b1;
        end
    end

`ifdef BM3D_SCHED_STAT_EN
    logic [19:0] stat_cnt;
    logic [19:0] stat_inc;

    assign stat_inc = (stat_cnt == '1) ? stat_cnt : stat_cnt + 20'd1;

    // Accepted-job counter; the frame total is captured with the last job
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt  <= '0;
            stat_jobs <= '0;
        end else begin
            if (hs && job_last) stat_jobs <= stat_inc;
            if (vs_rise || (hs && job_last)) stat_cnt <= '0;
            else if (hs)                     stat_cnt <= stat_inc;
        end
    end
`endif

endmodule

// File: tb/tb_bm3d_blk_sched.sv
// Directed bench for bm3d_blk_sched: instance A (IMG_H=12, depth 4) and
// instance B (IMG_H=13, depth 2) share camera timing, with separate job_ready.
module tb_bm3d_blk_sched;

    logic clk = 1'b0;
    logic rst, vsync, href, de;
    logic rdy_a, rdy_b;
    logic valid_a, last_a, busy_a, fd_a, ovf_a, abt_a;
    logic valid_b, last_b, busy_b, fd_b, ovf_b, abt_b;
    logic [4:0] x_a, y_a, x_b, y_b;
`ifdef BM3D_SCHED_STAT_EN
    logic [19:0] stat_a, stat_b;
`endif

    int vectors = 0;
    int miscompares = 0;
    bit rand_a = 1'b0;
    int cyc = 0;

    logic [4:0] qxa[$], qya[$], qxb[$], qyb[$];
    bit         qla[$], qlb[$];
    int fd_n_a, fd_cyc_a, last_cyc_a, fd_n_b, fd_cyc_b, last_cyc_b;
    int stab_bad = 0;
    bit prev_pend = 1'b0;
    logic [4:0] prev_x, prev_y;

    always #5 clk = ~clk;

    bm3d_blk_sched #(
        .IMG_W(16), .IMG_H(12), .BLK(4), .STEP(3), .CW(5), .PEND_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href), .cmos_de(de),
        .job_valid(valid_a), .job_ready(rdy_a), .job_x(x_a), .job_y(y_a),
        .job_last(last_a), .busy(busy_a), .frame_done(fd_a),
        .ovf_err(ovf_a), .abort_err(abt_a)
`ifdef BM3D_SCHED_STAT_EN
       ,.stat_jobs(stat_a)
`endif
    );

    bm3d_blk_sched #(
        .IMG_W(16), .IMG_H(13), .BLK(4), .STEP(3), .CW(5), .PEND_DEPTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href), .cmos_de(de),
        .job_valid(valid_b), .job_ready(rdy_b), .job_x(x_b), .job_y(y_b),
        .job_last(last_b), .busy(busy_b), .frame_done(fd_b),
        .ovf_err(ovf_b), .abort_err(abt_b)
`ifdef BM3D_SCHED_STAT_EN
       ,.stat_jobs(stat_b)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Handshake log, taken mid-cycle ahead of the edge that completes it
    always @(negedge clk) begin
        if (valid_a && rdy_a) begin
            qxa.push_back(x_a); qya.push_back(y_a); qla.push_back(last_a);
            if (last_a) last_cyc_a = cyc;
        end
        if (valid_b && rdy_b) begin
            qxb.push_back(x_b); qyb.push_back(y_b); qlb.push_back(last_b);
            if (last_b) last_cyc_b = cyc;
        end
        if (fd_a) begin fd_n_a++; fd_cyc_a = cyc; end
        if (fd_b) begin fd_n_b++; fd_cyc_b = cyc; end
        if (prev_pend && !(valid_a && x_a === prev_x && y_a === prev_y)) stab_bad++;
        prev_pend = valid_a && !rdy_a;
        prev_x = x_a;
        prev_y = y_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_a) rdy_a = ($urandom_range(0, 9) < 3);
    endtask

    task automatic clr();
        qxa.delete(); qya.delete(); qla.delete();
        qxb.delete(); qyb.delete(); qlb.delete();
        fd_n_a = 0; fd_cyc_a = 0; last_cyc_a = 0;
        fd_n_b = 0; fd_cyc_b = 0; last_cyc_b = 0;
    endtask

    task automatic frame(input int nrows, input int empty_at);
        vsync = 1'b1; repeat (2) tick();
        vsync = 1'b0; repeat (3) tick();
        for (int i = 0; i < nrows; i++) begin
            if (i == empty_at) begin
                href = 1'b1; repeat (16) tick();
                href = 1'b0; repeat (4) tick();
            end
            href = 1'b1; de = 1'b1; repeat (16) tick();
            href = 1'b0; de = 1'b0; repeat (4) tick();
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((busy_a || busy_b) && n < 3000) begin tick(); n++; end
        repeat (3) tick();
        chk(tag, 32'(n < 3000), 32'd1);
    endtask

    // Expected order: stripes y0 = 0,3,6,lasty; columns 0,3,6,9,12
    task automatic check_list(input string tag, input logic [4:0] qx[$],
                              input logic [4:0] qy[$], input bit ql[$], input int lasty);
        int ys[4];
        int n;
        ys = '{0, 3, 6, lasty};
        chk({tag, "_count"}, 32'(qx.size()), 32'd20);
        n = (qx.size() < 20) ? qx.size() : 20;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_x%0d", tag, i), 32'(qx[i]), 32'((i % 5) * 3));
            chk($sformatf("%s_y%0d", tag, i), 32'(qy[i]), 32'(ys[i / 5]));
            chk($sformatf("%s_last%0d", tag, i), 32'(ql[i]), 32'(i == 19));
        end
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; href = 1'b0; de = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        repeat (3) tick();
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_busy_a",  32'(busy_a),  32'd0);
        chk("rst_fd_a",    32'(fd_a),    32'd0);
        chk("rst_ovf_a",   32'(ovf_a),   32'd0);
        chk("rst_abt_a",   32'(abt_a),   32'd0);
        chk("rst_xy_a",    32'({x_a, y_a}), 32'd0);
        chk("rst_valid_b", 32'(valid_b), 32'd0);
        rst = 1'b0;
        tick();

        // Frame 1: ready tied high
        rdy_a = 1'b1; rdy_b = 1'b1;
        clr();
        frame(12, -1);
        drain("f1_drain");
        check_list("f1", qxa, qya, qla, 8);
        chk("f1_fd_count", 32'(fd_n_a), 32'd1);
        chk("f1_fd_gap", 32'(fd_cyc_a - last_cyc_a), 32'd1);
        chk("f1_ovf", 32'(ovf_a), 32'd0);
        chk("f1_abt", 32'(abt_a), 32'd0);
`ifdef BM3D_SCHED_STAT_EN
        chk("f1_stat", 32'(stat_a), 32'd20);
`endif

        // Frame 2: 30% ready backpressure on A
        clr();
        rand_a = 1'b1;
        frame(12, -1);
        drain("f2_drain");
        rand_a = 1'b0; rdy_a = 1'b1;
        check_list("f2", qxa, qya, qla, 8);
        chk("f2_fd_count", 32'(fd_n_a), 32'd1);
        chk("f2_stable", 32'(stab_bad), 32'd0);
        chk("f2_abt", 32'(abt_a), 32'd0);

        // Frame 3: both cores stalled, then A accepts 5 jobs, then vsync cuts
        clr();
        rdy_a = 1'b0; rdy_b = 1'b0;
        frame(12, -1);
        tick();
        chk("stall_valid_a", 32'(valid_a), 32'd1);
        chk("stall_xy_a", 32'({x_a, y_a}), 32'd0);
        chk("stall_ovf_a", 32'(ovf_a), 32'd0);
        chk("stall_ovf_b", 32'(ovf_b), 32'd1);
        rdy_a = 1'b1;
        repeat (5) tick();
        rdy_a = 1'b0;
        tick();
        chk("cut_pre_valid", 32'(valid_a), 32'd1);
        chk("cut_pre_y", 32'(y_a), 32'd3);
        vsync = 1'b1;
        tick();
        chk("cut_jobs", 32'(qxa.size()), 32'd5);
        chk("cut_valid_a", 32'(valid_a), 32'd0);
        chk("cut_busy_a", 32'(busy_a), 32'd0);
        chk("cut_abt_a", 32'(abt_a), 32'd1);
        chk("cut_abt_b", 32'(abt_b), 32'd1);
        chk("cut_fd", 32'(fd_n_a), 32'd0);
`ifdef BM3D_SCHED_STAT_EN
        chk("cut_stat", 32'(stat_a), 32'd20);
`endif
        vsync = 1'b0;
        repeat (4) tick();

        // Frame 4: 13 rows plus an empty line; A ignores row 12, B ends on y0=9
        clr();
        rdy_a = 1'b1; rdy_b = 1'b1;
        frame(13, 5);
        drain("f4_drain");
        check_list("f4a", qxa, qya, qla, 8);
        check_list("f4b", qxb, qyb, qlb, 9);
        chk("f4_fd_a", 32'(fd_n_a), 32'd1);
        chk("f4_fd_b_gap", 32'(fd_cyc_b - last_cyc_b), 32'd1);
        chk("f4_abt_sticky", 32'(abt_a), 32'd1);
        chk("f4_ovf_a", 32'(ovf_a), 32'd0);
`ifdef BM3D_SCHED_STAT_EN
        chk("f4_stat_a", 32'(stat_a), 32'd20);
        chk("f4_stat_b", 32'(stat_b), 32'd20);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
